vector_alu_seq: RTL and testbench

Time-multiplexed successor to the fully parallel vector element ALU. It processes an N-element vector through LANES physical lane ALUs over N/LANES beats, using a start/busy/done handshake. It also accumulates a wrapping sum-reduction of all results. It sits between the vector register file and the writeback/host interface, where area matters more than single-cycle throughput.

---
 rtl/vec_alu_pkg.sv | 26 ++
 rtl/vec_lane_alu.sv | 80 ++++++++
 rtl/vector_alu_seq.sv | 130 +++++++++++++
 tb/tb_vector_alu_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vec_alu_pkg.sv
// Shared types and helpers for the time-multiplexed vector ALU.
// Saturating arithmetic is enabled by defining VEC_ALU_SAT_EN.
package vec_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_CMP = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_NOT = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int beat_count(input int n, input int lanes);
        return n / lanes;
    endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Combinational single-lane signed ALU.
// Clamps ADD/SUB/MUL when VEC_ALU_SAT_EN is defined.
module vec_lane_alu
    import vec_alu_pkg::*;
#(
    parameter int BITS       = 8,
    parameter int MULT_SHIFT = 0
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  op_e             op,
    output logic [BITS-1:0] y,
    output logic            sat
);

`ifdef VEC_ALU_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [BITS-1:0] MAXV = {1'b0, {(BITS-1){1'b1}}};
    localparam logic [BITS-1:0] MINV = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [BITS-1:0] ONE  = {{(BITS-1){1'b0}}, 1'b1};

    logic signed [BITS:0]     sum;
    logic signed [BITS:0]     dif;
    logic signed [2*BITS-1:0] prod;
    logic signed [2*BITS-1:0] prod_sh;
    logic                     sum_ov;
    logic                     dif_ov;
    logic                     mul_ov;
    logic [BITS-1:0]          add_r;
    logic [BITS-1:0]          sub_r;
    logic [BITS-1:0]          mul_r;
    logic [BITS-1:0]          cmp_r;

    assign sum     = $signed({a[BITS-1], a}) + $signed({b[BITS-1], b});
    assign dif     = $signed({a[BITS-1], a}) - $signed({b[BITS-1], b});
    assign prod    = $signed(a) * $signed(b);
    assign prod_sh = prod >>> MULT_SHIFT;

    // Overflow: the kept sign bit disagrees with the discarded upper bits.
    assign sum_ov = sum[BITS] ^ sum[BITS-1];
    assign dif_ov = dif[BITS] ^ dif[BITS-1];
    assign mul_ov = !((&prod_sh[2*BITS-1:BITS-1]) ||
                      !(|prod_sh[2*BITS-1:BITS-1]));

    always_comb begin
        add_r = sum[BITS-1:0];
        sub_r = dif[BITS-1:0];
        mul_r = prod_sh[BITS-1:0];
        if (SAT_EN && sum_ov) add_r = sum[BITS] ? MINV : MAXV;
        if (SAT_EN && dif_ov) sub_r = dif[BITS] ? MINV : MAXV;
        if (SAT_EN && mul_ov) mul_r = prod_sh[2*BITS-1] ? MINV : MAXV;
    end

    always_comb begin
        cmp_r = ONE;
        if (sub_r == '0)        cmp_r = '0;
        else if (sub_r[BITS-1]) cmp_r = '1;
    end

    always_comb begin
        y   = '0;
        sat = 1'b0;
        unique case (op)
            OP_ADD: begin y = add_r; sat = SAT_EN && sum_ov; end
            OP_SUB: begin y = sub_r; sat = SAT_EN && dif_ov; end
            OP_MUL: begin y = mul_r; sat = SAT_EN && mul_ov; end
            OP_CMP: y = cmp_r;
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/vector_alu_seq.sv
// Vector ALU sequencing N elements through LANES lane ALUs per beat.
// Saturation (sat flag, clamping) is built in when VEC_ALU_SAT_EN is defined.
module vector_alu_seq
    import vec_alu_pkg::*;
#(
    parameter int BITS       = 8,
    parameter int N          = 64,
    parameter int LANES      = 8,
    parameter int MULT_SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N-1:0][BITS-1:0]   A,
    input  logic [N-1:0][BITS-1:0]   B,
    input  logic [BITS-1:0]          scalar,
    input  logic                     scalar_sel,
    input  logic [2:0]               op_sel,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [N-1:0][BITS-1:0]   S,
    output logic [BITS-1:0]          red_out,
    output logic                     sat
);

    localparam int BEATS = beat_count(N, LANES);
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if ((N % LANES) != 0 || LANES < 1 || LANES > N) begin : g_bad_cfg
            $error("vector_alu_seq: N must be a multiple of LANES");
        end
    endgenerate

    state_e state_q;
    state_e state_d;

    logic [KW-1:0]   k_q;
    op_e             op_q;
    logic            ssel_q;
    logic [BITS-1:0] scalar_q;
    logic [BITS-1:0] acc_q;
    logic            sat_q;

    logic [BEATS-1:0][LANES-1:0][BITS-1:0] s_q;
    logic [BEATS-1:0][LANES-1:0][BITS-1:0] a_v;
    logic [BEATS-1:0][LANES-1:0][BITS-1:0] b_v;

    logic [LANES-1:0][BITS-1:0] a_lane;
    logic [LANES-1:0][BITS-1:0] b_lane;
    logic [LANES-1:0][BITS-1:0] y_lane;
    logic [LANES-1:0]           sat_lane;
    logic [BITS-1:0]            beat_sum;

    assign a_v = A;
    assign b_v = B;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            a_lane[l] = a_v[k_q][l];
            b_lane[l] = ssel_q ? scalar_q : b_v[k_q][l];
        end
    end

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            vec_lane_alu #(
                .BITS       (BITS),
                .MULT_SHIFT (MULT_SHIFT)
            ) u_lane (
                .a   (a_lane[l]),
                .b   (b_lane[l]),
                .op  (op_q),
                .y   (y_lane[l]),
                .sat (sat_lane[l])
            );
        end
    endgenerate

    always_comb begin
        beat_sum = '0;
        for (int l = 0; l < LANES; l++) beat_sum = beat_sum + y_lane[l];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (k_q == KW'(BEATS-1)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q      <= '0;
            op_q     <= OP_ADD;
            ssel_q   <= 1'b0;
            scalar_q <= '0;
            acc_q    <= '0;
            sat_q    <= 1'b0;
            s_q      <= '0;
        end else if (state_q == IDLE && start) begin
            k_q      <= '0;
            op_q     <= op_e'(op_sel);
            ssel_q   <= scalar_sel;
            scalar_q <= scalar;
            acc_q    <= '0;
            sat_q    <= 1'b0;
        end else if (state_q == RUN) begin
            s_q[k_q] <= y_lane;
            acc_q    <= acc_q + beat_sum;
            sat_q    <= sat_q | (|sat_lane);
            k_q      <= k_q + 1'b1;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign S       = s_q;
    assign red_out = acc_q;
    assign sat     = sat_q;

endmodule

// File: tb/tb_vector_alu_seq.sv
// Directed self-checking bench for vector_alu_seq at default parameters.
// Saturation expectations follow VEC_ALU_SAT_EN.
module tb_vector_alu_seq;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [63:0][7:0] a;
    logic [63:0][7:0] b;
    logic [7:0]       scalar;
    logic             scalar_sel;
    logic [2:0]       op_sel;
    logic             start;
    logic             busy;
    logic             done;
    logic [63:0][7:0] s;
    logic [7:0]       red_out;
    logic             sat;

    logic [63:0][7:0] exp_s;
    logic [7:0]       exp_red;
    int               checks = 0;
    int               errors = 0;
    int               edges;
    int               dones;
    int               nz;

    vector_alu_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (a),
        .B          (b),
        .scalar     (scalar),
        .scalar_sel (scalar_sel),
        .op_sel     (op_sel),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .S          (s),
        .red_out    (red_out),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_vec(input string tag);
        exp_red = '0;
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("%s_s%0d", tag, i), 64'(s[i]), 64'(exp_s[i]));
            exp_red = exp_red + exp_s[i];
        end
        chk({tag, "_red"}, 64'(red_out), 64'(exp_red));
    endtask

    task automatic run(input logic [2:0] op, input logic ssel,
                       input logic [7:0] scal, output int n);
        @(posedge clk); #1;
        op_sel     = op;
        scalar_sel = ssel;
        scalar     = scal;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        a = '0; b = '0; scalar = '0; scalar_sel = 1'b0;
        op_sel = 3'b000; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s", 64'(s != '0), 64'd0);
        chk("rst_red", 64'(red_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sat", 64'(sat), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // ADD A[i]=i, B[i]=1
        for (int i = 0; i < 64; i++) begin
            a[i] = 8'(i); b[i] = 8'd1; exp_s[i] = 8'(i + 1);
        end
        run(3'b000, 1'b0, 8'h00, edges);
        chk("add_lat", 64'(edges), 64'd9);
        chk("add_done", 64'(done), 64'd1);
        chk("add_busy", 64'(busy), 64'd0);
        chk_vec("add");
        chk("add_red20", 64'(red_out), 64'h20);
        chk("add_sat", 64'(sat), 64'd0);
        @(posedge clk); #1;
        chk("add_done_pulse", 64'(done), 64'd0);

        // Scalar MUL: 3 * -2
        for (int i = 0; i < 64; i++) begin
            a[i] = 8'd3; b[i] = 8'($urandom); exp_s[i] = 8'hFA;
        end
        run(3'b010, 1'b1, 8'hFE, edges);
        chk("mul_lat", 64'(edges), 64'd9);
        chk_vec("mul");
        chk("mul_red80", 64'(red_out), 64'h80);

        // CMP: A=5, B cycles 4,5,6
        for (int i = 0; i < 64; i++) begin
            a[i] = 8'd5;
            b[i] = 8'(4 + i % 3);
            exp_s[i] = (i % 3 == 0) ? 8'h01 : (i % 3 == 1) ? 8'h00 : 8'hFF;
        end
        run(3'b011, 1'b0, 8'h00, edges);
        chk_vec("cmp");

        // Saturation boundary: 0x7F + 1
        for (int i = 0; i < 64; i++) begin
            a[i] = 8'h7F; b[i] = 8'h01;
`ifdef VEC_ALU_SAT_EN
            exp_s[i] = 8'h7F;
`else
            exp_s[i] = 8'h80;
`endif
        end
        run(3'b000, 1'b0, 8'h00, edges);
        chk_vec("satadd");
`ifdef VEC_ALU_SAT_EN
        chk("satadd_flag", 64'(sat), 64'd1);
`else
        chk("satadd_flag", 64'(sat), 64'd0);
`endif

        // Control isolation: XOR captured, controls disturbed during RUN
        for (int i = 0; i < 64; i++) begin
            a[i] = 8'(i); b[i] = 8'h55; exp_s[i] = 8'(i) ^ 8'h55;
        end
        @(posedge clk); #1;
        op_sel = 3'b110; scalar_sel = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("iso_busy", 64'(busy), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; op_sel = 3'b000; scalar_sel = 1'b1; scalar = 8'h09;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 4;
        while (!done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("iso_lat", 64'(edges), 64'd9);
        chk_vec("iso");
        dones = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("iso_no_2nd_done", 64'(dones), 64'd0);

        // Reset mid-operation during beat 3
        for (int i = 0; i < 64; i++) begin
            a[i] = 8'(i); b[i] = 8'd1; exp_s[i] = 8'(i + 1);
        end
        @(posedge clk); #1;
        op_sel = 3'b000; scalar_sel = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("mid_busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        nz = 0;
        for (int i = 0; i < 64; i++) if (s[i] != 8'h00) nz++;
        chk("mid_rst_s", 64'(nz), 64'd0);
        chk("mid_rst_red", 64'(red_out), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_sat", 64'(sat), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        run(3'b000, 1'b0, 8'h00, edges);
        chk("post_rst_lat", 64'(edges), 64'd9);
        chk_vec("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
